// File: rtl/scan_pkg.sv
// Shared definitions for the display scan select sequencer.
//   NUM_POS / SEL_W : number of scan positions and index width
//   DIR_UP/DIR_DOWN : encodings of the dir input
//   sel_t           : select index type
//   scan_state_e    : sequencer run state (idle until the first valid step)
package scan_pkg;
  localparam int unsigned NUM_POS  = 8;
  localparam int unsigned SEL_W    = 3;
  localparam logic        DIR_UP   = 1'b0;
  localparam logic        DIR_DOWN = 1'b1;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_state_e;
endpackage

// File: rtl/next_index_finder.sv
// Combinational search for the next enabled scan position.
//   mask    : bit i set = position i is visited
//   sel     : current position
//   dir     : DIR_UP ascending, DIR_DOWN descending
//   started : 0 = pick the first position of the frame (lowest/highest set bit)
//   target  : next position (sel when mask is empty)
//   any_set : mask has at least one bit set
//   wrap    : the step to target crosses the frame boundary
module next_index_finder
  import scan_pkg::*;
(
  input  logic [NUM_POS-1:0] mask,
  input  sel_t               sel,
  input  logic               dir,
  input  logic               started,
  output sel_t               target,
  output logic               any_set,
  output logic               wrap
);

  sel_t cand;

  always_comb begin
    target  = sel;
    any_set = |mask;
    wrap    = 1'b0;
    cand    = '0;
    if (!started) begin
      // Later hits overwrite earlier ones: scanning 7..0 leaves the lowest
      // set bit, scanning 0..7 leaves the highest.
      for (int unsigned k = 0; k < NUM_POS; k++) begin
        cand = (dir == DIR_UP) ? sel_t'(NUM_POS - 1 - k) : sel_t'(k);
        if (mask[cand]) target = cand;
      end
    end else begin
      // Distances 8 down to 1 so the nearest hit wins; distance 8 aliases to
      // sel itself, covering the single-bit mask case.
      for (int unsigned k = 0; k < NUM_POS; k++) begin
        cand = (dir == DIR_UP) ? sel + sel_t'(NUM_POS - k)
                               : sel - sel_t'(NUM_POS - k);
        if (mask[cand]) target = cand;
      end
      if (any_set) wrap = (dir == DIR_UP) ? (target <= sel) : (target >= sel);
    end
  end

endmodule

// File: rtl/scan_sel_sequencer.sv
// Select index sequencer feeding a 3-to-8 one-hot decoder for display scan.
// Steps sel through the positions enabled in mask every DIV cycles, in the
// direction given by dir, pulsing frame_done after each wrap-around.
//   clk, rst   : clock, synchronous active-high reset
//   en         : run enable (prescaler and index freeze when low)
//   dir        : 0 ascending, 1 descending
//   mask       : positions to visit
//   sel        : registered current index
//   sel_valid  : sel may be decoded
//   frame_done : one-cycle pulse after a wrapping step
// Optional macro SCAN_BLANK_EN: holds sel_valid low for BLANK_CYCLES cycles
// starting the cycle sel changes (ghosting dead-time).
module scan_sel_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned DIV          = 4,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               dir,
  input  logic [NUM_POS-1:0] mask,
  output sel_t               sel,
  output logic               sel_valid,
  output logic               frame_done
);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sel_t             sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             frame_q, frame_d;
  logic             tick;
  sel_t             target;
  logic             any_set;
  logic             wrap;

  assign tick = en && (cnt_q == CNT_W'(DIV - 1));

  next_index_finder u_finder (
    .mask    (mask),
    .sel     (sel_q),
    .dir     (dir),
    .started (state_q == ST_SCAN),
    .target  (target),
    .any_set (any_set),
    .wrap    (wrap)
  );

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    frame_d = 1'b0;
    if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (tick) begin
      if (!any_set) begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end else begin
        sel_d   = target;
        valid_d = 1'b1;
        state_d = ST_SCAN;
        frame_d = wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
    end
  end

  assign sel        = sel_q;
  assign frame_done = frame_q;

`ifdef SCAN_BLANK_EN
  logic [CNT_W-1:0] blank_q, blank_d;

  // Reload wins over decrement so the loaded value is seen in full.
  always_comb begin
    blank_d = blank_q;
    if (blank_q != '0) blank_d = blank_q - 1'b1;
    if (tick && any_set && (target != sel_q)) blank_d = CNT_W'(BLANK_CYCLES);
  end

  always_ff @(posedge clk) begin
    if (rst) blank_q <= '0;
    else     blank_q <= blank_d;
  end

  assign sel_valid = valid_q && (blank_q == '0);
`else
  // Dead-time length only matters when blanking is built in.
  logic [31:0] unused_blank_cycles;
  assign unused_blank_cycles = BLANK_CYCLES;
  assign sel_valid = valid_q;
`endif

endmodule

// File: doc/scan_sel_sequencer.md
Name: scan_sel_sequencer

Overview:
- Upstream stage of the 3-to-8 one-hot select decoder. Produces the 3-bit select index that the decoder expands into its one-hot enable.
- Steps the index through the eight positions at a prescaled rate. Skips masked-off positions, supports up and down direction, and flags the end of each frame.
- Typical use: digit/anode scanning for an 8-position multiplexed display, with this block's sel wired directly to the decoder's sel.

Parameters:
- DIV, 4, clock cycles per step; legal range 2..65535.
- CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W >= DIV.
- BLANK_CYCLES, 1, dead-time length in cycles; used only when SCAN_BLANK_EN is defined; legal range 1..DIV-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  run enable; when low, prescaler and index freeze.
- dir  input  1  0 = ascending index, 1 = descending index.
- mask  input  8  bit i = 1 means index i is visited.
- sel  output  3  current index, registered.
- sel_valid  output  1  sel refers to an enabled index and may be decoded.
- frame_done  output  1  one-cycle pulse on wrap-around.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: sel=0, sel_valid=0, frame_done=0, prescaler cnt=0, started=0. rst has priority over every other input.
- Prescaler:
  - If en=1: when cnt==DIV-1, cnt<=0 and a step tick is raised for that cycle; otherwise cnt<=cnt+1.
  - If en=0: cnt holds, no tick, frame_done=0.
- Step target on tick (combinational search, resolved in one cycle):
  - Not started: target is the lowest set mask bit when dir=0, or the highest set mask bit when dir=1. Then started<=1 and sel_valid<=1. No frame_done on this step.
  - Started: target is the next set mask bit after sel, searching circularly in dir order, excluding sel itself.
  - If sel is the only set bit, target = sel. It still counts as a wrap, so frame_done pulses.
- Latency: sel updates on the edge that ends the tick cycle. With en held high from reset, the first valid sel appears DIV cycles after rst deasserts.
- Wrap-around and frame_done:
  - dir=0: wrap occurs when target <= sel. dir=1: wrap occurs when target >= sel.
  - frame_done=1 in the cycle after a wrapping tick only; otherwise 0.
- Empty mask (mask==0):
  - On tick: sel holds, sel_valid<=0, started<=0, no frame_done.
  - When mask later becomes non-zero, the next tick restarts as "not started".
- Mask change mid-scan:
  - sel is not disturbed between ticks. sel_valid stays 1 even if mask[sel] drops.
  - The change takes effect at the next tick.
- dir change mid-scan: takes effect at the next tick; the search starts from the current sel.
- en deassert: sel, sel_valid and cnt hold. The partial count resumes when en returns.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of cnt or frame position.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined:
  - sel_valid is forced to 0 for BLANK_CYCLES cycles starting the cycle sel changes. This is ghosting dead-time.
  - Implemented with a small down-counter loaded on each step.
  - A tick where target == sel does not blank.
  - frame_done timing is unchanged.
- Not defined: sel_valid behaves exactly as described above, and no dead-time logic exists.

Decomposition:
- Shared package scan_pkg:
  - constant NUM_POS = 8
  - constant SEL_W = 3
  - constants DIR_UP = 0 and DIR_DOWN = 1
  - typedef sel_t as a SEL_W-bit logic
- Sub-module next_index_finder:
  - Purely combinational.
  - Inputs: mask, current sel, dir, started.
  - Outputs: target, any_set, wrap.
  - Verified standalone, exhaustively over all 2^8 x 8 x 2 x 2 input combinations.

Test Plan (DIV=4 unless stated):
- Reset then en=1, mask=8'hFF, dir=0 -> sel_valid rises at cycle 4. sel steps 0,1,...,7,0 every 4 cycles. frame_done pulses once, in the cycle after the 7->0 step.
- mask=8'b1010_0100, dir=0 -> sel sequence 2,5,7,2,5. frame_done after each 7->2 step. dir=1 from sel=5 -> next sel 2, then 7 with frame_done.
- mask=8'h10 -> sel=4 on every tick, frame_done pulses every 4 cycles. Set mask=0 -> next tick sel_valid=0 and sel holds 4. Restore mask=8'h01 -> next tick sel=0, sel_valid=1, no frame_done.
- en=0 for 10 cycles mid-scan at cnt=2 -> sel, sel_valid and cnt frozen. The step occurs 2 cycles after en returns.
- rst asserted one cycle while sel=6, cnt=3 -> next edge sel=0, sel_valid=0, frame_done=0, cnt=0.
- SCAN_BLANK_EN, BLANK_CYCLES=2, mask=8'hFF -> sel_valid low for exactly 2 cycles after each step and high for the remaining 2. mask=8'h08 -> no blanking.
